// File: rtl/id_ex_stage_reg_if.sv
// ID -> EX pipeline bus: decoded instruction from ID, registered copy toward EX,
// MEM-stage writeback info for hazard detection, and the stall/perf outputs.
interface id_ex_stage_reg_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             freeze;
  logic             flush;
  logic             valid_in;
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] val_rn_in;
  logic [WIDTH-1:0] val_rm_in;
  logic [3:0]       src1;
  logic [3:0]       src2;
  logic             use_src1;
  logic             two_src;
  logic [3:0]       dest_in;
  logic [3:0]       exe_cmd_in;
  logic             mem_r_en_in;
  logic             mem_w_en_in;
  logic             wb_en_in;
  logic             b_in;
  logic             s_in;
  logic             imm_in;
  logic [11:0]      shift_operand_in;
  logic [23:0]      signed_imm24_in;
  logic             c_in;
  logic [3:0]       mem_dest;
  logic             mem_wb_en;

  logic             hazard;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] val_rn_out;
  logic [WIDTH-1:0] val_rm_out;
  logic [3:0]       src1_out;
  logic [3:0]       src2_out;
  logic [3:0]       dest_out;
  logic [3:0]       exe_cmd_out;
  logic             mem_r_en_out;
  logic             mem_w_en_out;
  logic             wb_en_out;
  logic             b_out;
  logic             s_out;
  logic             imm_out;
  logic             c_out;
  logic             valid_out;
  logic [11:0]      shift_operand_out;
  logic [23:0]      signed_imm24_out;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output freeze, flush, valid_in, pc_in, val_rn_in, val_rm_in, src1, src2,
           use_src1, two_src, dest_in, exe_cmd_in, mem_r_en_in, mem_w_en_in,
           wb_en_in, b_in, s_in, imm_in, shift_operand_in, signed_imm24_in,
           c_in, mem_dest, mem_wb_en,
    input  hazard, pc_out, val_rn_out, val_rm_out, src1_out, src2_out,
           dest_out, exe_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out,
           b_out, s_out, imm_out, c_out, valid_out, shift_operand_out,
           signed_imm24_out, bubble_cnt
  );

  modport slave (
    input  freeze, flush, valid_in, pc_in, val_rn_in, val_rm_in, src1, src2,
           use_src1, two_src, dest_in, exe_cmd_in, mem_r_en_in, mem_w_en_in,
           wb_en_in, b_in, s_in, imm_in, shift_operand_in, signed_imm24_in,
           c_in, mem_dest, mem_wb_en,
    output hazard, pc_out, val_rn_out, val_rm_out, src1_out, src2_out,
           dest_out, exe_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out,
           b_out, s_out, imm_out, c_out, valid_out, shift_operand_out,
           signed_imm24_out, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with RAW hazard detection, bubble insertion,
// flush/freeze handling and a saturating bubble counter.
module id_ex_stage_reg #(
  parameter int WIDTH      = 32,
  parameter bit FORWARD_EN = 1'b0,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              rst,
  id_ex_stage_reg_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] val_rn;
    logic [WIDTH-1:0] val_rm;
    logic [3:0]       src1;
    logic [3:0]       src2;
    logic [3:0]       dest;
    logic [3:0]       exe_cmd;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             wb_en;
    logic             b;
    logic             s;
    logic             imm;
    logic             c;
    logic             valid;
    logic [11:0]      shift_operand;
    logic [23:0]      signed_imm24;
  } stage_t;

  stage_t           stage_q;
  stage_t           stage_d;
  stage_t           incoming;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [3:0] src_addr [2];
  logic [1:0] src_used;
  logic [1:0] ex_match;
  logic [1:0] mem_match;
  logic       hazard_raw;

  assign src_addr[0] = bus.src1;
  assign src_addr[1] = bus.src2;
  assign src_used    = {bus.two_src, bus.use_src1} & {2{bus.valid_in}};

  // With forwarding only a load in EX cannot be bypassed; without it any
  // pending writer in EX or MEM blocks the reader.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign ex_match[gi]  = stage_q.valid & stage_q.wb_en
                           & (stage_q.dest == src_addr[gi])
                           & (FORWARD_EN ? stage_q.mem_r_en : 1'b1);
      assign mem_match[gi] = (FORWARD_EN == 1'b0) & bus.mem_wb_en
                           & (bus.mem_dest == src_addr[gi]);
    end
  endgenerate

  assign hazard_raw = |(src_used & (ex_match | mem_match));
  assign bus.hazard = hazard_raw & ~rst;

  always_comb begin
    incoming               = '0;
    incoming.pc            = bus.pc_in;
    incoming.val_rn        = bus.val_rn_in;
    incoming.val_rm        = bus.val_rm_in;
    incoming.src1          = bus.src1;
    incoming.src2          = bus.src2;
    incoming.dest          = bus.dest_in;
    incoming.exe_cmd       = bus.exe_cmd_in;
    incoming.mem_r_en      = bus.mem_r_en_in;
    incoming.mem_w_en      = bus.mem_w_en_in;
    incoming.wb_en         = bus.wb_en_in;
    incoming.b             = bus.b_in;
    incoming.s             = bus.s_in;
    incoming.imm           = bus.imm_in;
    incoming.c             = bus.c_in;
    incoming.valid         = bus.valid_in;
    incoming.shift_operand = bus.shift_operand_in;
    incoming.signed_imm24  = bus.signed_imm24_in;
  end

  // A bubble is the all-zero stage: no writeback, no memory access, no branch.
  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (!bus.freeze) begin
      if (bus.flush) begin
        stage_d = '0;
      end else if (hazard_raw) begin
        stage_d = '0;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (!bus.valid_in) begin
        stage_d = '0;
      end else begin
        stage_d = incoming;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_out            = stage_q.pc;
  assign bus.val_rn_out        = stage_q.val_rn;
  assign bus.val_rm_out        = stage_q.val_rm;
  assign bus.src1_out          = stage_q.src1;
  assign bus.src2_out          = stage_q.src2;
  assign bus.dest_out          = stage_q.dest;
  assign bus.exe_cmd_out       = stage_q.exe_cmd;
  assign bus.mem_r_en_out      = stage_q.mem_r_en;
  assign bus.mem_w_en_out      = stage_q.mem_w_en;
  assign bus.wb_en_out         = stage_q.wb_en;
  assign bus.b_out             = stage_q.b;
  assign bus.s_out             = stage_q.s;
  assign bus.imm_out           = stage_q.imm;
  assign bus.c_out             = stage_q.c;
  assign bus.valid_out         = stage_q.valid;
  assign bus.shift_operand_out = stage_q.shift_operand;
  assign bus.signed_imm24_out  = stage_q.signed_imm24;
  assign bus.bubble_cnt        = cnt_q;

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Pipeline register between the ID stage (register file read, control decode) and the EX stage of the 5-stage ARM core.
- Captures register-file operands, immediates and control bits each cycle.
- Contains the RAW hazard detector: inserts a bubble into EX and asserts a stall toward IF/ID.
- Honours branch flush and global freeze, and keeps a saturating bubble counter for performance monitoring.

Parameters:
WIDTH, 32, datapath width of PC and operand values
FORWARD_EN, 0, 1 = forwarding unit present (stall only on load-use); 0 = stall on any EX/MEM RAW dependency
CNT_W, 16, width of bubble counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
freeze  in  1  hold all state (memory stall)
flush  in  1  branch taken in EX; squash incoming instruction
valid_in  in  1  ID instruction is real (not bubble)
pc_in  in  WIDTH  PC+4 of ID instruction
val_rn_in, val_rm_in  in  WIDTH  register-file reads (reg1, reg2)
src1, src2  in  4  register-file read addresses
use_src1, two_src  in  1  instruction actually reads src1 / src2
dest_in  in  4  destination register
exe_cmd_in  in  4  ALU command
mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in  in  1  control bits
imm_in  in  1  immediate operand select
shift_operand_in  in  12  shifter operand
signed_imm24_in  in  24  branch offset
c_in  in  1  status-register carry
mem_dest  in  4  MEM-stage destination
mem_wb_en  in  1  MEM-stage writeback enable
hazard  out  1  combinational stall request to PC and IF/ID
pc_out, val_rn_out, val_rm_out  out  WIDTH  registered
src1_out, src2_out, dest_out, exe_cmd_out  out  4  registered
mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, imm_out, c_out, valid_out  out  1  registered
shift_operand_out  out  12  registered
signed_imm24_out  out  24  registered
bubble_cnt  out  CNT_W  bubbles inserted since reset

Behaviour:
- Reset: every registered output and bubble_cnt = 0 immediately, independent of clk.
- Latency: 1 cycle; values present at rising edge N appear on outputs after edge N.
- Hazard (combinational, from inputs and current registered outputs):
  - hit1 = valid_in & use_src1; hit2 = valid_in & two_src.
  - EX match: valid_out & wb_en_out & dest_out == src. With FORWARD_EN=1, EX match additionally requires mem_r_en_out.
  - MEM match: mem_wb_en & mem_dest == src; used only when FORWARD_EN=0.
  - hazard = (hit1 & (EX match on src1 | MEM match on src1)) | (hit2 & (EX match on src2 | MEM match on src2)).
  - hazard is 0 during rst.
- Update at each rising edge, priority top-down:
  - freeze: hold all state; bubble_cnt unchanged; hazard still driven.
  - flush: load bubble (all control bits incl. valid_out = 0; data fields = 0); not counted.
  - hazard: load bubble; bubble_cnt += 1, saturating at all-ones.
  - otherwise: load all inputs; valid_out = valid_in.
- Bubble definition: wb_en, mem_r_en, mem_w_en, b, s, valid = 0. Guarantees no architectural side effect.
- valid_in = 0 loads as a bubble-equivalent; not counted, no hazard.
- src/dest = 15 get no special treatment.
- Simultaneous flush and hazard: flush wins and the counter does not increment.
- Reset mid-stall: hazard drops to 0 and state clears; the next edge after rst deasserts loads normally.

Test Plan:
1. Assert rst mid-cycle with outputs non-zero -> all outputs and bubble_cnt = 0 before next clk edge.
2. FORWARD_EN=0. EX holds wb_en=1, dest=3, valid. ID src1=3, use_src1=1 -> hazard=1; next edge valid_out=0, wb_en_out=0, bubble_cnt=1. Then MEM match (mem_dest=3, mem_wb_en=1) keeps hazard=1 for a second bubble (bubble_cnt=2).
3. FORWARD_EN=1, same EX dependency with mem_r_en_out=0 -> hazard=0, instruction loads. With mem_r_en_out=1 -> exactly one bubble.
4. two_src=0, src2 matches EX dest -> hazard=0. two_src=1 -> hazard=1.
5. freeze=1 with pc_in changing 0x10->0x14 -> pc_out stays at old value, bubble_cnt stable even with hazard=1.
6. flush=1 and hazard=1 together -> valid_out=0 and bubble_cnt unchanged. Separately, run bubble_cnt at 0xFFFF (CNT_W=16) with hazard=1 -> stays 0xFFFF.
